minmax_tracker: RTL and testbench

Sequential stage directly downstream of the 4-bit magnitude comparator. It accepts a stream of unsigned samples over a valid/ready handshake and compares each sample against the running max, running min and previous sample. After N_SAMPLES accepted samples it presents max, min, rise count and fall count over a valid/ready result handshake. It is the first block in the lab datapath that holds state around the compare logic.

---
 rtl/minmax_tracker_pkg.sv | 15 +
 rtl/mag_cmp.sv | 19 +
 rtl/minmax_tracker.sv | 175 +++++++++++++++++
 tb/tb_minmax_tracker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_tracker_pkg.sv
// Shared definitions for the min/max/rise/fall window tracker.
package minmax_tracker_pkg;

    // Default sample width and window length.
    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_N_SAMPLES = 8;

    // FSM state encoding; 2'b11 is illegal and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator with mutually exclusive gt/lt/eq outputs.
module mag_cmp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    // Equality wins, so exactly one of gt/lt/eq is ever set.
    always_comb begin
        eq = (a == b);
        gt = !eq && (a > b);
        lt = !eq && !(a > b);
    end

endmodule

// File: rtl/minmax_tracker.sv
// Window tracker: running max, min and rise/fall counts over N_SAMPLES
// accepted samples, presented over a valid/ready result handshake.
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned N_SAMPLES = DEFAULT_N_SAMPLES,
    parameter int unsigned CW        = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [CW-1:0]    rise_cnt,
    output logic [CW-1:0]    fall_cnt,
    output logic             busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    rise_q;
    logic [CW-1:0]    fall_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             res_valid_q;
    logic             busy_q;

    logic             max_gt, max_lt, max_eq;
    logic             min_gt, min_lt, min_eq;
    logic             prev_gt, prev_lt, prev_eq;
    logic             accept;
    logic             take;
    logic [CW-1:0]    cnt_inc;

    // Three parallel compares of the incoming sample against pre-edge state.
    mag_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gt (max_gt),
        .lt (max_lt),
        .eq (max_eq)
    );

    mag_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gt (min_gt),
        .lt (min_lt),
        .eq (min_eq)
    );

    mag_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp_prev (
        .a  (in_data),
        .b  (prev_q),
        .gt (prev_gt),
        .lt (prev_lt),
        .eq (prev_eq)
    );

    // Handshake qualifiers and the incremented sample count.
    always_comb begin
        accept  = in_valid && in_ready_q;
        take    = res_valid_q && res_ready;
        cnt_inc = cnt_q + CNT_ONE;
    end

    // FSM with datapath registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ST_IDLE;
            max_q       <= '0;
            min_q       <= '0;
            prev_q      <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        max_q  <= in_data;
                        min_q  <= in_data;
                        prev_q <= in_data;
                        rise_q <= '0;
                        fall_q <= '0;
                        cnt_q  <= CNT_ONE;
                        busy_q <= 1'b1;
                        if (N_SAMPLES == 1) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (!max_eq && max_gt) begin
                            max_q <= in_data;
                        end
                        if (!min_eq && min_lt) begin
                            min_q <= in_data;
                        end
                        if (prev_gt) begin
                            rise_q <= rise_q + CNT_ONE;
                        end else if (prev_lt) begin
                            fall_q <= fall_q + CNT_ONE;
                        end
                        prev_q <= in_data;
                        cnt_q  <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result registers stay put until the next window's first sample.
                    if (take) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Output ports driven straight from registers.
    always_comb begin
        in_ready  = in_ready_q;
        res_valid = res_valid_q;
        busy      = busy_q;
        max_val   = max_q;
        min_val   = min_q;
        rise_cnt  = rise_q;
        fall_cnt  = fall_q;
    end

    // Unused compare outputs kept for symmetry of the three compare lanes.
    logic unused_cmp;
    always_comb begin
        unused_cmp = max_lt ^ min_gt;
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: a 4-sample window instance and a
// single-sample window instance, checked against hand-computed values.
module tb_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst;

    // N_SAMPLES = 4 instance
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] max_val;
    logic [3:0] min_val;
    logic [2:0] rise_cnt;
    logic [2:0] fall_cnt;
    logic       busy;

    // N_SAMPLES = 1 instance
    logic       s_clear;
    logic       s_in_valid;
    logic [3:0] s_in_data;
    logic       s_in_ready;
    logic       s_res_valid;
    logic       s_res_ready;
    logic [3:0] s_max_val;
    logic [3:0] s_min_val;
    logic [0:0] s_rise_cnt;
    logic [0:0] s_fall_cnt;
    logic       s_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    minmax_tracker #(
        .WIDTH    (4),
        .N_SAMPLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .max_val  (max_val),
        .min_val  (min_val),
        .rise_cnt (rise_cnt),
        .fall_cnt (fall_cnt),
        .busy     (busy)
    );

    minmax_tracker #(
        .WIDTH    (4),
        .N_SAMPLES(1)
    ) dut_one (
        .clk      (clk),
        .rst      (rst),
        .clear    (s_clear),
        .in_valid (s_in_valid),
        .in_data  (s_in_data),
        .in_ready (s_in_ready),
        .res_valid(s_res_valid),
        .res_ready(s_res_ready),
        .max_val  (s_max_val),
        .min_val  (s_min_val),
        .rise_cnt (s_rise_cnt),
        .fall_cnt (s_fall_cnt),
        .busy     (s_busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic check_res(input string tag, input int mx, input int mn,
                             input int r, input int f);
        check_eq({tag, ".max"}, int'(max_val), mx);
        check_eq({tag, ".min"}, int'(min_val), mn);
        check_eq({tag, ".rise"}, int'(rise_cnt), r);
        check_eq({tag, ".fall"}, int'(fall_cnt), f);
    endtask

    task automatic check_ctl(input string tag, input int rdy, input int vld, input int bsy);
        check_eq({tag, ".in_ready"}, int'(in_ready), rdy);
        check_eq({tag, ".res_valid"}, int'(res_valid), vld);
        check_eq({tag, ".busy"}, int'(busy), bsy);
    endtask

    // Take the result with in_valid low; back to IDLE with values held.
    task automatic take_result(input string tag);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_ctl({tag, ".taken"}, 1, 0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        res_ready   = 1'b0;
        s_clear     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_ctl("reset", 1, 0, 0);
        check_res("reset", 0, 0, 0, 0);

        // Back-to-back window 5,3,9,9
        push(4'd5);
        check_ctl("w1.s1", 1, 0, 1);
        push(4'd3);
        push(4'd9);
        check_eq("w1.s3.res_valid", int'(res_valid), 0);
        push(4'd9);
        in_valid = 1'b0;
        check_ctl("w1.done", 0, 1, 1);
        check_res("w1", 9, 3, 1, 1);
        take_result("w1");
        check_res("w1.after", 9, 3, 1, 1);

        // Same window with idle gaps
        push(4'd5);
        in_valid = 1'b0;
        tick();
        tick();
        check_res("w2.gap", 5, 5, 0, 0);
        push(4'd3);
        in_valid = 1'b0;
        tick();
        push(4'd9);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check_ctl("w2.gap3", 1, 0, 1);
        push(4'd9);
        in_valid = 1'b0;
        check_ctl("w2.done", 0, 1, 1);
        check_res("w2", 9, 3, 1, 1);

        // HOLD with res_ready low while sample 7 is offered
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_ctl("hold.stall", 0, 1, 1);
            check_res("hold.stall", 9, 3, 1, 1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_ctl("hold.taken", 1, 0, 0);
        check_eq("hold.taken.max", int'(max_val), 9);
        tick();
        in_valid = 1'b0;
        check_ctl("w3.first", 1, 0, 1);
        check_res("w3.first", 7, 7, 0, 0);

        // Clear with a sample offered: sample dropped, everything zero
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd15;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_ctl("clr0", 1, 0, 0);
        check_res("clr0", 0, 0, 0, 0);

        // Clear after two samples, then window 1,2,3,4
        push(4'd4);
        push(4'd12);
        in_valid = 1'b0;
        check_res("w4.pre", 12, 4, 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_ctl("clr1", 1, 0, 0);
        check_res("clr1", 0, 0, 0, 0);
        push(4'd1);
        push(4'd2);
        push(4'd3);
        push(4'd4);
        in_valid = 1'b0;
        check_ctl("w5.done", 0, 1, 1);
        check_res("w5", 4, 1, 3, 0);
        take_result("w5");

        // rst mid-ACCUM with a sample offered
        push(4'd8);
        push(4'd2);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd15;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_ctl("rst_mid", 1, 0, 0);
        check_res("rst_mid", 0, 0, 0, 0);
        tick();
        check_res("rst_mid.idle", 0, 0, 0, 0);

        // Extreme values 0,15,0,15
        push(4'd0);
        push(4'd15);
        push(4'd0);
        push(4'd15);
        in_valid = 1'b0;
        check_ctl("edge.done", 0, 1, 1);
        check_res("edge", 15, 0, 2, 1);
        take_result("edge");

        // Single-sample window goes straight to HOLD
        check_eq("one.reset.ready", int'(s_in_ready), 1);
        check_eq("one.reset.busy", int'(s_busy), 0);
        s_in_valid = 1'b1;
        s_in_data  = 4'd6;
        tick();
        s_in_valid = 1'b0;
        check_eq("one.res_valid", int'(s_res_valid), 1);
        check_eq("one.in_ready", int'(s_in_ready), 0);
        check_eq("one.busy", int'(s_busy), 1);
        check_eq("one.max", int'(s_max_val), 6);
        check_eq("one.min", int'(s_min_val), 6);
        check_eq("one.rise", int'(s_rise_cnt), 0);
        check_eq("one.fall", int'(s_fall_cnt), 0);
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        check_eq("one.taken.res_valid", int'(s_res_valid), 0);
        check_eq("one.taken.in_ready", int'(s_in_ready), 1);
        check_eq("one.taken.max", int'(s_max_val), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
